// File: rtl/ntt_sched_pkg.sv
// Shared types and constants for the NTT butterfly pass scheduler.
// State encoding, output-network select codes and default BFU latency.
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  localparam logic [1:0] SEL_BF0_LO = 2'b00;
  localparam logic [1:0] SEL_BF0_UP = 2'b01;
  localparam logic [1:0] SEL_BF1_LO = 2'b10;
  localparam logic [1:0] SEL_BF1_UP = 2'b11;

  localparam int BF_LAT_DEF = 7;

  typedef struct packed {
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] s3;
  } sel_bundle_t;

  function automatic sel_bundle_t sel_pack(
    input logic [1:0] a,
    input logic [1:0] b,
    input logic [1:0] c,
    input logic [1:0] d
  );
    sel_bundle_t r;
    r.s0 = a;
    r.s1 = b;
    r.s2 = c;
    r.s3 = d;
    return r;
  endfunction

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
// Carries the issue strobe and address to the write side.
module sched_delay_line #(
  parameter int DEPTH = 7,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         clr_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  // shift one stage per cycle; clear wipes every stage
  always_ff @(posedge clk) begin
    if (!clr_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_bf_out_sched.sv
// Issue/write sequencer for one radix-2 NTT pass on the 2-BFU datapath.
// Optional busy-cycle counter enabled by NTT_SCHED_PERF_CNT_EN.
module ntt_bf_out_sched
  import ntt_sched_pkg::*;
#(
  parameter int N      = 256,
  parameter int LOG_N  = 8,
  parameter int ADDR_W = 6,
  parameter int BF_LAT = BF_LAT_DEF,
  localparam int STAGE_W = $clog2(LOG_N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [STAGE_W-1:0] stage,
  output logic [1:0]         sel_a_0,
  output logic [1:0]         sel_a_1,
  output logic [1:0]         sel_a_2,
  output logic [1:0]         sel_a_3,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [15:0]        cycle_cnt
);

  localparam int DW = $clog2(BF_LAT + 1);

  localparam logic [ADDR_W-1:0] CNT_LAST =
    ADDR_W'(N / 4 - 1);
  localparam logic [STAGE_W-1:0] ST_LAST =
    STAGE_W'(LOG_N - 1);
  localparam logic [STAGE_W-1:0] ST_PEN =
    STAGE_W'(LOG_N - 2);
  localparam logic [DW-1:0] DRAIN_INIT =
    DW'(BF_LAT - 1);

  sched_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [DW-1:0]      drain_q, drain_d;
  sel_bundle_t        sel_q, sel_d;
  sel_bundle_t        sel_tab;
  logic               issue;
  logic [ADDR_W:0]    wr_pipe;

  // next state, issue strobe and counter updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    drain_d = drain_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (stage_q == ST_LAST) begin
              stage_d = '0;
              drain_d = DRAIN_INIT;
              state_d = S_DRAIN;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // output-network routing per stage; last stage alternates on cnt parity
  always_comb begin
    sel_tab = sel_pack(SEL_BF0_UP, SEL_BF0_LO,
                       SEL_BF1_UP, SEL_BF1_LO);
    unique case (1'b1)
      (stage_q == ST_LAST) && cnt_q[0]:
        sel_tab = sel_pack(SEL_BF0_LO, SEL_BF1_LO,
                           SEL_BF0_UP, SEL_BF1_UP);
      (stage_q == ST_LAST) && !cnt_q[0]:
        sel_tab = sel_pack(SEL_BF0_UP, SEL_BF1_UP,
                           SEL_BF0_LO, SEL_BF1_LO);
      (stage_q == ST_PEN):
        sel_tab = sel_pack(SEL_BF0_UP, SEL_BF1_UP,
                           SEL_BF0_LO, SEL_BF1_LO);
      default: ;
    endcase
    sel_d = issue ? sel_tab : sel_q;
  end

  // FSM and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      drain_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
      sel_q   <= sel_d;
    end
  end

  sched_delay_line #(
    .DEPTH (BF_LAT),
    .W     (ADDR_W + 1)
  ) u_wr_dly (
    .clk    (clk),
    .clr_ni (rst),
    .d_i    ({issue, cnt_q}),
    .q_o    (wr_pipe)
  );

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign rd_en   = issue;
  assign rd_addr = cnt_q;
  assign stage   = stage_q;
  assign sel_a_0 = sel_d.s0;
  assign sel_a_1 = sel_d.s1;
  assign sel_a_2 = sel_d.s2;
  assign sel_a_3 = sel_d.s3;
  assign wr_en   = wr_pipe[ADDR_W];
  assign wr_addr = wr_pipe[ADDR_W-1:0];

`ifdef NTT_SCHED_PERF_CNT_EN
  logic [15:0] cc_q, cc_d;

  // busy cycles since the last accept, saturating
  always_comb begin
    cc_d = cc_q;
    if ((state_q == S_IDLE) && start) begin
      cc_d = '0;
    end else if (busy && (cc_q != 16'hFFFF)) begin
      cc_d = cc_q + 16'd1;
    end
  end

  // perf counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cc_q <= '0;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign cycle_cnt = cc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_ntt_bf_out_sched.sv
// Self-checking bench for ntt_bf_out_sched (default parameters).
// Expected write traffic is scoreboarded from the issue model.
module tb_ntt_bf_out_sched;

  localparam int N      = 256;
  localparam int LOG_N  = 8;
  localparam int ADDR_W = 6;
  localparam int BF_LAT = 7;
  localparam int Q      = N / 4;
  localparam int ISSUES = Q * LOG_N;
  localparam int SW     = 3;
`ifdef NTT_SCHED_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, stall;
  logic              busy, done, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [SW-1:0]     stage;
  logic [1:0]        sel_a_0, sel_a_1, sel_a_2, sel_a_3;
  logic [15:0]       cycle_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
  } wr_exp_t;

  wr_exp_t wrq[$];

  ntt_bf_out_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .stage     (stage),
    .sel_a_0   (sel_a_0),
    .sel_a_1   (sel_a_1),
    .sel_a_2   (sel_a_2),
    .sel_a_3   (sel_a_3),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_sel(input int k);
    int s;
    int c;
    s = k / Q;
    c = k % Q;
    if (s <= LOG_N - 3) return 8'b01_00_11_10;
    if (s == LOG_N - 2) return 8'b01_11_00_10;
    if ((c % 2) == 0) return 8'b01_11_00_10;
    return 8'b00_10_01_11;
  endfunction

  task automatic step(input logic st, input logic sl,
                      input logic r);
    @(posedge clk);
    #1;
    cyc++;
    start = st;
    stall = sl;
    rst   = r;
    #1;
  endtask

  task automatic test_reset();
    logic [40:0] got;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      got = {busy, done, rd_en, rd_addr, stage,
             sel_a_0, sel_a_1, sel_a_2, sel_a_3,
             wr_en, wr_addr, cycle_cnt};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset_%0d got=%h exp=0", i, got);
      end
      step(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_pass(input string nm, input int stall_k,
                           input int stall_len, input bit poke,
                           input bit chain, output int done_at);
    int exp_done, k, ns, t;
    bit sl, st, exp_rd;
    logic [17:0] got_r, exp_r;
    logic [ADDR_W:0] got_w, exp_w;
    logic [1:0] got_h, exp_h;
    logic [15:0] exp_cc;
    exp_done = ISSUES + BF_LAT + 1 + stall_len;
    wrq.delete();
    k = 0;
    ns = 0;
    done_at = -1;
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if ({busy, done, rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle got=%b exp=000", nm,
               {busy, done, rd_en});
    end
    for (t = 1; t <= exp_done + (chain ? 0 : 1); t++) begin
      sl = (k == stall_k) && (ns < stall_len) && (k < ISSUES);
      st = poke && ((t == 100) || (t == exp_done));
      step(st, sl, 1'b1);
      if (sl) ns++;
      if (done === 1'b1 && done_at < 0) done_at = cyc;
      exp_rd = (k < ISSUES) && !sl;
      if (k < ISSUES) begin
        exp_r = {exp_rd, ADDR_W'(k % Q), SW'(k / Q),
                 exp_sel(sl ? k - 1 : k)};
        got_r = {rd_en, rd_addr, stage,
                 sel_a_0, sel_a_1, sel_a_2, sel_a_3};
      end else begin
        exp_r = '0;
        got_r = {rd_en, 17'd0};
      end
      checks++;
      if (got_r !== exp_r) begin
        errors++;
        $display("FAIL %s_rd t=%0d got=%h exp=%h",
                 nm, t, got_r, exp_r);
      end
      if (exp_rd) begin
        wrq.push_back('{due: cyc + BF_LAT,
                        addr: ADDR_W'(k % Q)});
        k++;
      end
      if (wrq.size() > 0 && wrq[0].due == cyc) begin
        exp_w = {1'b1, wrq[0].addr};
        got_w = {wr_en, wr_addr};
        void'(wrq.pop_front());
      end else begin
        exp_w = '0;
        got_w = {wr_en, {ADDR_W{1'b0}}};
      end
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL %s_wr t=%0d got=%h exp=%h",
                 nm, t, got_w, exp_w);
      end
      exp_h = {t <= exp_done, t == exp_done};
      got_h = {busy, done};
      checks++;
      if (got_h !== exp_h) begin
        errors++;
        $display("FAIL %s_busy_done t=%0d got=%b exp=%b",
                 nm, t, got_h, exp_h);
      end
      exp_cc = PERF ? 16'(t - 1) : 16'd0;
      checks++;
      if (cycle_cnt !== exp_cc) begin
        errors++;
        $display("FAIL %s_cycle_cnt t=%0d got=%0d exp=%0d",
                 nm, t, cycle_cnt, exp_cc);
      end
    end
    if (!chain) begin
      step(1'b0, 1'b0, 1'b1);
      exp_cc = PERF ? 16'(exp_done) : 16'd0;
      checks++;
      if ({busy, done, wr_en, cycle_cnt} !==
          {3'b000, exp_cc}) begin
        errors++;
        $display("FAIL %s_hold got=%b/%0d exp=000/%0d", nm,
                 {busy, done, wr_en}, cycle_cnt, exp_cc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, d0, d1;
    base = cyc + 1;
    test_pass("b2b_first", -1, 0, 1'b1, 1'b1, d0);
    test_pass("b2b_second", -1, 0, 1'b0, 1'b0, d1);
    checks++;
    if (d1 - base !== 1041) begin
      errors++;
      $display("FAIL b2b_done_cycle got=%0d exp=1041",
               d1 - base);
    end
  endtask

  task automatic test_mid_reset();
    logic [40:0] got;
    int dmy;
    step(1'b1, 1'b0, 1'b1);
    for (int t = 1; t < 300; t++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    got = {busy, done, rd_en, rd_addr, stage,
           sel_a_0, sel_a_1, sel_a_2, sel_a_3,
           wr_en, wr_addr, cycle_cnt};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got=%h exp=0", got);
    end
    for (int t = 302; t < 840; t++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
        errors++;
        $display("FAIL midrst_quiet t=%0d got=%b exp=0000",
                 t, {busy, done, rd_en, wr_en});
      end
    end
    test_pass("midrst_fresh", -1, 0, 1'b0, 1'b0, dmy);
  endtask

  initial begin
    int d;
    rst   = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    test_reset();
    test_pass("nominal", -1, 0, 1'b0, 1'b0, d);
    test_pass("stall", 2 * Q + 10, 3, 1'b0, 1'b0, d);
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
